// File: rtl/counter_pkg.sv
// Shared mode encodings and default width for the multi-mode counter and its bench.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [1:0] MODE_UP3  = 2'b00;
    localparam logic [1:0] MODE_DN1  = 2'b01;
    localparam logic [1:0] MODE_UP1  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Combinational next-state for the multi-mode counter: value, carry/borrow and load flag.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_q,
    output logic             next_rco,
    output logic             next_load
);

    localparam int unsigned W1 = WIDTH + 1;

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] sum_up3;
    logic [WIDTH:0] sum_up1;
    logic [WIDTH:0] diff_dn1;

    // One extra bit on every operation so its MSB is the carry (or borrow) out.
    assign q_ext    = {1'b0, q};
    assign sum_up3  = q_ext + W1'(3);
    assign sum_up1  = q_ext + W1'(1);
    assign diff_dn1 = q_ext - W1'(1);

    // Select the result for the requested mode; rco and load are mutually exclusive.
    always_comb begin
        next_q    = q;
        next_rco  = 1'b0;
        next_load = 1'b0;
        case (mode)
            MODE_UP3: begin
                next_q   = sum_up3[WIDTH-1:0];
                next_rco = sum_up3[WIDTH];
            end
            MODE_DN1: begin
                next_q   = diff_dn1[WIDTH-1:0];
                next_rco = diff_dn1[WIDTH];
            end
            MODE_UP1: begin
                next_q   = sum_up1[WIDTH-1:0];
                next_rco = sum_up1[WIDTH];
            end
            MODE_LOAD: begin
                next_q    = d;
                next_load = 1'b1;
            end
            default: begin
                next_q = q;
            end
        endcase
    end

endmodule : counter_next

// File: rtl/counter_4b_modes.sv
// Multi-mode counter top: enable gating, synchronous reset and the output registers.
// rco is registered so low.rco can drive high.enable when two stages cascade.
module counter_4b_modes
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             load_q, load_d;

    logic [WIDTH-1:0] next_q;
    logic             next_rco;
    logic             next_load;

    counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q         (q_q),
        .mode      (mode),
        .d         (D),
        .next_q    (next_q),
        .next_rco  (next_rco),
        .next_load (next_load)
    );

    // Hold Q and drop the pulses when disabled, so mode/D are ignored entirely.
    always_comb begin
        q_d    = q_q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        if (enable) begin
            q_d    = next_q;
            rco_d  = next_rco;
            load_d = next_load;
        end
    end

    // State and output registers; reset wins over any operation on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            rco_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rco_q  <= rco_d;
            load_q <= load_d;
        end
    end

    assign Q    = q_q;
    assign rco  = rco_q;
    assign load = load_q;

endmodule : counter_4b_modes
